// File: rtl/inv_key_schedule_pkg.sv
// Shared AES definitions for the inverse AES-128 key schedule: widths, round type,
// FSM state encodings, Rcon table and the forward S-box.
package inv_key_schedule_pkg;

    localparam int KEY_W = 128;

    typedef logic [3:0] round_t;
    localparam round_t ROUND_LAST = 4'd10;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EMIT = 2'd1;
    localparam state_t ST_WAIT = 2'd2;

    // Indexed by the round being stepped away from: RCON[r] produces round r-1.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Request/round-key bus between a key consumer (master) and the inverse key schedule (slave).
interface inv_key_schedule_if;
    import inv_key_schedule_pkg::*;

    logic             start;
    logic [KEY_W-1:0] key_in;
    logic             ready;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    round_t           round_out;
    logic             done;

    modport master (
        output start, key_in,
        input  ready, key_out, key_valid, round_out, done
    );

    modport slave (
        input  start, key_in,
        output ready, key_out, key_valid, round_out, done
    );
endinterface

// File: rtl/inv_key_schedule_key_subword.sv
// SubWord: four forward S-box lookups on a 32-bit word.
// With INV_KEY_SBOX_REG_EN defined the result is registered (one cycle latency).
module key_subword
    import inv_key_schedule_pkg::*;
(
`ifdef INV_KEY_SBOX_REG_EN
    input  logic        clk_i,
`endif
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    logic [31:0] sub;

    assign sub = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                  sbox(word_i[15:8]),  sbox(word_i[7:0])};

`ifdef INV_KEY_SBOX_REG_EN
    // NOTE: pure datapath register, left without reset; the FSM only consumes it one cycle after loading.
    always_ff @(posedge clk_i) begin
        word_o <= sub;
    end
`else
    assign word_o = sub;
`endif

endmodule

// File: rtl/inv_key_schedule.sv
// Inverse AES-128 key schedule: walks from the round-10 key back to round 0, one key per beat.
// INV_KEY_SBOX_REG_EN registers the S-box and inserts a WAIT cycle between beats.
module inv_key_schedule
    import inv_key_schedule_pkg::*;
(
    input logic               clk,
    input logic               rst,
    inv_key_schedule_if.slave bus
);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    round_t           round_q, round_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] w0_n, w1_n, w2_n, w3_n;
    logic [31:0] rot_w, sub_w;
    logic [KEY_W-1:0] prev_key;

    assign {w0, w1, w2, w3} = key_q;

    // Undo the forward recurrence: w3' must be recovered before it can feed SubWord.
    assign w3_n  = w3 ^ w2;
    assign w2_n  = w2 ^ w1;
    assign w1_n  = w1 ^ w0;
    assign rot_w = {w3_n[23:0], w3_n[31:24]};
    assign w0_n  = w0 ^ sub_w ^ {RCON[round_q], 24'h0};
    assign prev_key = {w0_n, w1_n, w2_n, w3_n};

    key_subword u_subword (
`ifdef INV_KEY_SBOX_REG_EN
        .clk_i  (clk),
`endif
        .word_i (rot_w),
        .word_o (sub_w)
    );

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no latches are inferred.
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key_in;
                    round_d = ROUND_LAST;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (round_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
`ifdef INV_KEY_SBOX_REG_EN
                    state_d = ST_WAIT;
`else
                    key_d   = prev_key;
                    round_d = round_q - 4'd1;
`endif
                end
            end
`ifdef INV_KEY_SBOX_REG_EN
            ST_WAIT: begin
                key_d   = prev_key;
                round_d = round_q - 4'd1;
                state_d = ST_EMIT;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.key_valid = (state_q == ST_EMIT);
    assign bus.done      = (state_q == ST_EMIT) && (round_q == 4'd0);
    assign bus.key_out   = key_q;
    assign bus.round_out = round_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: beat timing, key values, ignored starts,
// mid-sequence reset, reset/start priority and back-to-back sequences.
module tb_inv_key_schedule;

`ifdef INV_KEY_SBOX_REG_EN
    localparam int SPACING = 2;
`else
    localparam int SPACING = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    logic [127:0] exp_keys [0:1][0:10];

    inv_key_schedule_if bus ();

    inv_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present start at a negedge; returns at the negedge where the first beat is due.
    task automatic do_start(input logic [127:0] k);
        check("start_ready", 128'(bus.ready), 128'd1);
        bus.start  = 1'b1;
        bus.key_in = k;
        @(negedge clk);
    endtask

    // Entered at the first-beat negedge. pulse_a/pulse_b: beat indices at which a stray
    // start is raised; abort_beat: beat index after which rst is applied; hold keeps start high.
    task automatic run_beats(input int sel, input int pulse_a, input int pulse_b,
                             input int abort_beat, input bit hold);
        for (int c = 0; c <= SPACING * 10; c++) begin
            bit beat;
            int b;
            int r;
            if (c > 0) @(negedge clk);
            beat = (c % SPACING == 0);
            b    = c / SPACING;
            r    = 10 - b;
            if (beat) begin
                check($sformatf("valid_r%0d", r), 128'(bus.key_valid), 128'd1);
                check($sformatf("round_r%0d", r), 128'(bus.round_out), 128'(r));
                check($sformatf("key_r%0d", r),   bus.key_out,         exp_keys[sel][r]);
                check($sformatf("done_r%0d", r),  128'(bus.done),      128'(r == 0));
            end else begin
                check($sformatf("gap_valid_r%0d", r), 128'(bus.key_valid), 128'd0);
                check($sformatf("gap_done_r%0d", r),  128'(bus.done),      128'd0);
            end
            check($sformatf("busy_ready_c%0d", c), 128'(bus.ready), 128'd0);
            bus.start = hold || (beat && (b == pulse_a || b == pulse_b));
            if (beat && b == abort_beat) begin
                rst       = 1'b1;
                bus.start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check("abort_ready",     128'(bus.ready),     128'd1);
                check("abort_valid",     128'(bus.key_valid), 128'd0);
                check("abort_done",      128'(bus.done),      128'd0);
                check("abort_key",       bus.key_out,         128'd0);
                check("abort_round",     128'(bus.round_out), 128'd0);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check($sformatf("abort_quiet_%0d", i), 128'(bus.key_valid), 128'd0);
                end
                return;
            end
        end
        @(negedge clk);
        bus.start = hold;
        check("post_ready", 128'(bus.ready),     128'd1);
        check("post_valid", 128'(bus.key_valid), 128'd0);
    endtask

    initial begin
        // FIPS-197 example key schedule, indexed by round.
        exp_keys[0][0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_keys[0][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_keys[0][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_keys[0][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_keys[0][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_keys[0][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_keys[0][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_keys[0][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_keys[0][8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_keys[0][9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_keys[0][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        // All-zero cipher key schedule.
        exp_keys[1][0]  = 128'h00000000000000000000000000000000;
        exp_keys[1][1]  = 128'h62636363626363636263636362636363;
        exp_keys[1][2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
        exp_keys[1][3]  = 128'h90973450696ccffaf2f457330b0fac99;
        exp_keys[1][4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
        exp_keys[1][5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
        exp_keys[1][6]  = 128'hec614b851425758c99ff09376ab49ba7;
        exp_keys[1][7]  = 128'h217517873550620bacaf6b3cc61bf09b;
        exp_keys[1][8]  = 128'h0ef903333ba9613897060a04511dfa9f;
        exp_keys[1][9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
        exp_keys[1][10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.key_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 128'(bus.ready),     128'd1);
        check("rst_valid", 128'(bus.key_valid), 128'd0);
        check("rst_done",  128'(bus.done),      128'd0);
        check("rst_key",   bus.key_out,         128'd0);
        check("rst_round", 128'(bus.round_out), 128'd0);

        // Plain sequence, then with stray starts on beats 3 and 7.
        do_start(exp_keys[0][10]);
        run_beats(0, -1, -1, -1, 1'b0);
        repeat (3) @(negedge clk);
        check("idle_valid", 128'(bus.key_valid), 128'd0);
        do_start(exp_keys[0][10]);
        run_beats(0, 2, 6, -1, 1'b0);
        @(negedge clk);
        check("stray_idle_valid", 128'(bus.key_valid), 128'd0);

        // Second key pattern.
        do_start(exp_keys[1][10]);
        run_beats(1, -1, -1, -1, 1'b0);

        // Reset after beat 5, then reset wins over a simultaneous start.
        do_start(exp_keys[0][10]);
        run_beats(0, -1, -1, 4, 1'b0);
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.key_in = exp_keys[1][10];
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("prio_valid", 128'(bus.key_valid), 128'd0);
        check("prio_ready", 128'(bus.ready),     128'd1);
        @(negedge clk);
        check("prio_quiet", 128'(bus.key_valid), 128'd0);
        do_start(exp_keys[0][10]);
        run_beats(0, -1, -1, -1, 1'b0);

        // Back-to-back: start held high; second first beat lands at T_done+2.
        do_start(exp_keys[0][10]);
        run_beats(0, -1, -1, -1, 1'b1);
        @(negedge clk);
        run_beats(0, -1, -1, -1, 1'b0);
        repeat (2) @(negedge clk);
        check("final_valid", 128'(bus.key_valid), 128'd0);
        check("final_ready", 128'(bus.ready),     128'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
